// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe: operands and op select flow in,
// result and flags flow out, each side with its own valid/ready pair.
interface adder_pipe_if #(
  parameter int OPERAND_LENGTH = 32
);
  logic [OPERAND_LENGTH-1:0] opd1;
  logic [OPERAND_LENGTH-1:0] opd2;
  logic [3:0]                alu_op_select;
  logic                      carry_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [OPERAND_LENGTH-1:0] adder_result;
  logic                      carry_out;
  logic                      overflow;
  logic                      zero;
  logic                      negative;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output opd1, opd2, alu_op_select, carry_in, in_valid, out_ready,
    input  in_ready, adder_result, carry_out, overflow, zero, negative, out_valid
  );

  modport slave (
    input  opd1, opd2, alu_op_select, carry_in, in_valid, out_ready,
    output in_ready, adder_result, carry_out, overflow, zero, negative, out_valid
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES segments, one segment
// resolved per register stage, with valid/ready handshakes on both ends.
module adder_pipe #(
  parameter int OPERAND_LENGTH = 32,
  parameter int STAGES         = 2
) (
  input logic        clk,
  input logic        rst,
  adder_pipe_if.slave bus
);

  if (STAGES < 1 || (OPERAND_LENGTH % STAGES) != 0) begin : g_bad_params
    $error("adder_pipe: OPERAND_LENGTH must be a positive multiple of STAGES >= 1");
  end

  localparam int W   = OPERAND_LENGTH;
  localparam int SEG = OPERAND_LENGTH / STAGES;

  // Stage k holds result bits for segments 0..k, the still-pending operand
  // segments above k, the carry into segment k+1 and a zero-so-far bit.
  typedef struct packed {
    logic         valid;
    logic [W-1:0] res;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry;
    logic         zero_run;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t head;
  stage_t last;
  logic   adv;
  logic   sub;

  assign sub  = bus.alu_op_select[3];
  assign last = stage_q[STAGES-1];
  assign adv  = !last.valid || bus.out_ready;

  always_comb begin
    head.valid    = bus.in_valid;
    head.res      = '0;
    head.a        = bus.opd1;
    head.b        = sub ? ~bus.opd2 : bus.opd2;
    head.carry    = sub ? 1'b1 : bus.carry_in;
    head.zero_run = 1'b1;
  end

  // NOTE: every variable in an always_comb gets a value before any branch or
  // loop reads it, so no path can leave it holding state (no latch inferred).
  always_comb begin
    stage_t     src;
    logic [SEG:0] seg_sum;
    src     = head;
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      src     = (k == 0) ? head : stage_q[k-1];
      seg_sum = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.b[k*SEG +: SEG]}
              + {{SEG{1'b0}}, src.carry};
      stage_d[k]                    = src;
      stage_d[k].res[k*SEG +: SEG]  = seg_sum[SEG-1:0];
      stage_d[k].carry              = seg_sum[SEG];
      stage_d[k].zero_run           = src.zero_run && (seg_sum[SEG-1:0] == '0);
    end
  end

  // NOTE: sequential state is written with <= so every stage samples the
  // pre-edge value of its predecessor; blocking = here would collapse the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        // Bubbles only clear the valid bit, so outputs keep their last value.
        if (stage_d[k].valid) stage_q[k] <= stage_d[k];
        else                  stage_q[k].valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = adv;
  assign bus.out_valid    = last.valid;
  assign bus.adder_result = last.res;
  assign bus.carry_out    = last.carry;
  assign bus.zero         = last.zero_run;
  assign bus.negative     = last.res[W-1];
  assign bus.overflow     = (last.a[W-1] == last.b[W-1]) && (last.res[W-1] != last.a[W-1]);

  logic unused_bits;
  assign unused_bits = ^{bus.alu_op_select[2:0], last.a[W-2:0], last.b[W-2:0]};

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: flag vectors on a 2-stage instance, cross-segment
// carry on 1/2/4-stage instances, backpressure streaming and mid-flight reset.
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opd1, opd2;
  logic [3:0]  op;
  logic        cin, in_valid, out_ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_pipe_if #(.OPERAND_LENGTH(32)) if1 ();
  adder_pipe_if #(.OPERAND_LENGTH(32)) if2 ();
  adder_pipe_if #(.OPERAND_LENGTH(32)) if4 ();

  assign if1.opd1 = opd1; assign if1.opd2 = opd2; assign if1.alu_op_select = op;
  assign if1.carry_in = cin; assign if1.in_valid = in_valid; assign if1.out_ready = out_ready;
  assign if2.opd1 = opd1; assign if2.opd2 = opd2; assign if2.alu_op_select = op;
  assign if2.carry_in = cin; assign if2.in_valid = in_valid; assign if2.out_ready = out_ready;
  assign if4.opd1 = opd1; assign if4.opd2 = opd2; assign if4.alu_op_select = op;
  assign if4.carry_in = cin; assign if4.in_valid = in_valid; assign if4.out_ready = out_ready;

  adder_pipe #(.OPERAND_LENGTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  adder_pipe #(.OPERAND_LENGTH(32), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  adder_pipe #(.OPERAND_LENGTH(32), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags2();
    return {if2.carry_out, if2.overflow, if2.zero, if2.negative};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat through the 2-stage instance; flags packed as {c, v, z, n}.
  task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic ci,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    opd1 = a; opd2 = b; op = sel; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!if2.out_valid && lat < 8) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " result"}, if2.adder_result, exp_res);
    check({tag, " flags"}, flags2(), exp_flags);
  endtask

  initial begin
    int tx, rx, stalls, lat1, lat2, lat4, vcount;
    logic [31:0] held, r1, r2, r4;

    rst = 1'b1; opd1 = '0; opd2 = '0; op = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12 rst = 1'b0;
    #1;
    check("reset out_valid", if2.out_valid, 0);
    check("reset result", if2.adder_result, 0);
    check("reset flags", flags2(), 4'b0000);
    check("reset in_ready", if2.in_ready, 1);
    step();

    send_one("add 1+5",        32'd1,        32'd5,        4'b0000, 1'b0, 32'd6,        4'b0000);
    send_one("sub 6-7",        32'd6,        32'd7,        4'b1000, 1'b0, 32'hFFFFFFFF, 4'b0001);
    send_one("sub ffff-fffe",  32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 1'b0, 32'd1,        4'b1000);
    send_one("sub 6-6",        32'd6,        32'd6,        4'b1000, 1'b0, 32'd0,        4'b1010);
    send_one("add 7fff+1",     32'h7FFFFFFF, 32'd1,        4'b0000, 1'b0, 32'h80000000, 4'b0101);
    send_one("add ffff+fffe",  32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0000, 1'b0, 32'hFFFFFFFD, 4'b1001);
    send_one("adc ffff+0+1",   32'hFFFFFFFF, 32'd0,        4'b0000, 1'b1, 32'd0,        4'b1010);
    send_one("sub ignores cin",32'd10,       32'd3,        4'b1000, 1'b1, 32'd7,        4'b1000);
    send_one("op low ignored", 32'd2,        32'd3,        4'b0111, 1'b0, 32'd5,        4'b0000);

    // Cross-segment carry through all three pipeline depths at once.
    repeat (4) step();
    opd1 = 32'h0000FFFF; opd2 = 32'd1; op = 4'b0000; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0; r1 = '0; r2 = '0; r4 = '0;
    for (int c = 1; c <= 8; c++) begin
      if (if1.out_valid && lat1 == 0) begin lat1 = c; r1 = if1.adder_result; end
      if (if2.out_valid && lat2 == 0) begin lat2 = c; r2 = if2.adder_result; end
      if (if4.out_valid && lat4 == 0) begin lat4 = c; r4 = if4.adder_result; end
      step();
    end
    check("xseg s1 latency", lat1, 1);
    check("xseg s2 latency", lat2, 2);
    check("xseg s4 latency", lat4, 4);
    check("xseg s1 result", r1, 32'h00010000);
    check("xseg s2 result", r2, 32'h00010000);
    check("xseg s4 result", r4, 32'h00010000);

    // Eight back-to-back beats i + 2i with a 3-cycle downstream stall.
    tx = 0; rx = 0; stalls = 0; held = '0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (tx < 8);
      opd1 = 32'(tx); opd2 = 32'(2 * tx); op = 4'b0000; cin = 1'b0;
      #1;
      if (if2.out_valid && !out_ready) begin
        if (stalls == 0) held = if2.adder_result;
        else check("bp hold result", if2.adder_result, held);
        check("bp in_ready low", if2.in_ready, 0);
        stalls++;
      end
      if (if2.out_valid && out_ready) begin
        check($sformatf("bp beat %0d", rx), if2.adder_result, 32'(3 * rx));
        rx++;
      end
      if (in_valid && if2.in_ready) tx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp beats received", rx, 8);
    check("bp stall cycles", stalls, 3);

    // Reset with two beats in flight.
    repeat (3) step();
    opd1 = 32'd3; opd2 = 32'd4; in_valid = 1'b1;
    step();
    opd1 = 32'd8; opd2 = 32'd9;
    step();
    in_valid = 1'b0;
    check("rst pre valid", if2.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst out_valid", if2.out_valid, 0);
    check("rst result", if2.adder_result, 0);
    check("rst flags", flags2(), 4'b0000);
    check("rst in_ready", if2.in_ready, 1);
    step();
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (if2.out_valid) vcount++;
    end
    check("rst no stale beat", vcount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
